// File: rtl/riscv_selfcheck_pkg.sv
// Shared types and helpers for the riscv_core self-check monitor.
// Holds the FSM state encoding and signature/popcount helpers.
package riscv_selfcheck_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        READ,
        DONE
    } state_t;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 6;

    function automatic logic [31:0] exp_sig(
        input logic [15:0] prefix,
        input int          k
    );
        logic [15:0] num;
        num = 16'(k + 1);
        return {prefix, num};
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [31:0] half_word(
        input logic [63:0] d,
        input logic        hi
    );
        return hi ? d[63:32] : d[31:0];
    endfunction

endpackage

// File: rtl/riscv_selfcheck_monitor_if.sv
// Read bus between the self-check monitor and the TCM.
// One outstanding request, accept/ack handshake.
interface riscv_selfcheck_monitor_if;
    import riscv_selfcheck_pkg::*;

    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_accept_i;
    logic              mem_ack_i;
    logic              mem_error_i;
    logic [DATA_W-1:0] mem_data_i;

    modport master (
        output mem_rd_o,
        output mem_addr_o,
        input  mem_accept_i,
        input  mem_ack_i,
        input  mem_error_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_rd_o,
        input  mem_addr_o,
        output mem_accept_i,
        output mem_ack_i,
        output mem_error_i,
        output mem_data_i
    );

endinterface

// File: rtl/riscv_selfcheck_rdseq.sv
// Result-block read sequencer: walks NUM_BEATS 64-bit reads.
// Holds the request until accept, issues the next after ack.
module riscv_selfcheck_rdseq
    import riscv_selfcheck_pkg::*;
#(
    parameter int          NUM_BEATS = 6,
    parameter logic [31:0] BASE      = 32'h80009000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    riscv_selfcheck_monitor_if.master mem,
    output logic             beat,
    output logic [IDX_W-1:0] beat_idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              pend;
    logic [IDX_W-1:0]  idx;
    logic              acc;

    assign mem.mem_rd_o   = rd;
    assign mem.mem_addr_o = addr;

    assign acc      = rd & mem.mem_accept_i;
    assign beat     = mem.mem_ack_i & (pend | acc);
    assign beat_idx = idx;
    assign last     = beat & (idx == LAST_IDX);

    // Request/ack tracking; an ack with nothing outstanding is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd   <= 1'b0;
            addr <= '0;
            pend <= 1'b0;
            idx  <= '0;
        end else if (start) begin
            rd   <= 1'b1;
            addr <= BASE;
            pend <= 1'b0;
            idx  <= '0;
        end else begin
            if (acc) begin
                rd <= 1'b0;
            end
            pend <= (pend | acc) & ~mem.mem_ack_i;
            if (beat && idx != LAST_IDX) begin
                idx  <= idx + 1'b1;
                addr <= addr + 32'd8;
                rd   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_selfcheck_monitor.sv
// End-of-test self-check and performance monitor for riscv_core.
// Counts cycles/retires in RUN, then reads and checks the signature.
module riscv_selfcheck_monitor
    import riscv_selfcheck_pkg::*;
#(
    parameter int          NUM_PIPES      = 2,
    parameter int          NUM_TESTS      = 10,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] RESULT_BASE    = 32'h80009000,
    parameter int          DRAIN_CYCLES   = 10,
    parameter int          TIMEOUT_CYCLES = 200000,
    parameter logic [15:0] SIG_PREFIX     = 16'h600D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PIPES-1:0] retire_valid_i,
    input  logic                 trigger_i,
    riscv_selfcheck_monitor_if.master mem,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic [6:0]           pass_count_o,
    output logic [NUM_TESTS-1:0] fail_mask_o,
    output logic [CNT_W-1:0]     cycle_count_o,
    output logic [CNT_W-1:0]     instr_count_o
);

    localparam int NW = (NUM_TESTS + 3) / 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int SUM_W = CNT_W + 7;

    state_t state;
    logic [31:0] drain_cnt;
    logic sw_pass_ok;
    logic sw_total_ok;
    logic error_seen;

    logic start;
    logic beat;
    logic last;
    logic [IDX_W-1:0] beat_idx;

    logic [CNT_W-1:0] cyc_next;
    logic [CNT_W-1:0] ins_next;
    logic [SUM_W-1:0] ins_sum;
    logic timed_out;

    logic rd_beat;
    logic [NUM_TESTS-1:0] mask_n;
    logic [6:0] pc_n;
    logic swp_n;
    logic swt_n;
    logic err_n;
    logic [31:0] w;

    assign start = (state == DRAIN) &&
                   (drain_cnt == 32'(DRAIN_CYCLES - 1));
    assign rd_beat = beat && (state == READ);

    riscv_selfcheck_rdseq #(
        .NUM_BEATS (NW),
        .BASE      (RESULT_BASE)
    ) u_rdseq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem      (mem),
        .beat     (beat),
        .beat_idx (beat_idx),
        .last     (last)
    );

    // Saturating next values of the counters and the timeout condition.
    always_comb begin
        cyc_next = (cycle_count_o == CNT_MAX) ?
                   cycle_count_o : cycle_count_o + 1'b1;
        ins_sum = SUM_W'(instr_count_o) +
                  SUM_W'(popcount(32'(retire_valid_i)));
        ins_next = (ins_sum > SUM_W'(CNT_MAX)) ?
                   CNT_MAX : ins_sum[CNT_W-1:0];
        timed_out = !trigger_i &&
                    (64'(cyc_next) >= 64'(TIMEOUT_CYCLES));
    end

    // Compare both 32-bit words of the current beat.
    always_comb begin
        mask_n = fail_mask_o;
        pc_n   = pass_count_o;
        swp_n  = sw_pass_ok;
        swt_n  = sw_total_ok;
        err_n  = error_seen;
        w      = '0;
        if (rd_beat) begin
            if (mem.mem_error_i) begin
                err_n = 1'b1;
            end
            for (int t = 0; t < NUM_TESTS; t++) begin
                if (int'(beat_idx) == t / 2) begin
                    w = half_word(mem.mem_data_i, 1'(t % 2));
                    if (mem.mem_error_i ||
                        w != exp_sig(SIG_PREFIX, t)) begin
                        mask_n[t] = 1'b1;
                    end else begin
                        pc_n = pc_n + 7'd1;
                    end
                end
            end
            if (int'(beat_idx) == NUM_TESTS / 2) begin
                swp_n = !mem.mem_error_i &&
                        (half_word(mem.mem_data_i,
                                   1'(NUM_TESTS % 2)) ==
                         32'(NUM_TESTS));
            end
            if (int'(beat_idx) == (NUM_TESTS + 1) / 2) begin
                swt_n = !mem.mem_error_i &&
                        (half_word(mem.mem_data_i,
                                   1'((NUM_TESTS + 1) % 2)) ==
                         32'(NUM_TESTS));
            end
        end
    end

    // Main FSM with counters and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            sw_pass_ok    <= 1'b0;
            sw_total_ok   <= 1'b0;
            error_seen    <= 1'b0;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            timeout_o     <= 1'b0;
            pass_count_o  <= '0;
            fail_mask_o   <= '0;
            cycle_count_o <= '0;
            instr_count_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= RUN;
                end
                RUN: begin
                    cycle_count_o <= cyc_next;
                    instr_count_o <= ins_next;
                    if (trigger_i) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else if (timed_out) begin
                        state     <= DONE;
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        pass_o    <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (start) begin
                        state <= READ;
                    end else begin
                        drain_cnt <= drain_cnt + 32'd1;
                    end
                end
                READ: begin
                    fail_mask_o  <= mask_n;
                    pass_count_o <= pc_n;
                    sw_pass_ok   <= swp_n;
                    sw_total_ok  <= swt_n;
                    error_seen   <= err_n;
                    if (last) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        pass_o <= (mask_n == '0) && swp_n &&
                                  swt_n && !err_n && !timeout_o;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_selfcheck_monitor.sv
// Directed bench for riscv_selfcheck_monitor.
// Main instance plus short-timeout and narrow-counter instances.
module tb_riscv_selfcheck_monitor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] retire = 2'b00;
    logic trig = 1'b0;
    logic trig_off = 1'b0;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    riscv_selfcheck_monitor_if mif ();
    riscv_selfcheck_monitor_if tif ();
    riscv_selfcheck_monitor_if sif ();

    logic done, pass, tmo;
    logic [6:0] pcnt;
    logic [9:0] mask;
    logic [31:0] cyc, ins;

    logic t_done, t_pass, t_tmo;
    logic [6:0] t_pcnt;
    logic [9:0] t_mask;
    logic [31:0] t_cyc, t_ins;

    logic s_done, s_pass, s_tmo;
    logic [6:0] s_pcnt;
    logic [9:0] s_mask;
    logic [3:0] s_cyc, s_ins;

    riscv_selfcheck_monitor u_main (
        .clk (clk), .rst (rst),
        .retire_valid_i (retire), .trigger_i (trig),
        .mem (mif.master),
        .done_o (done), .pass_o (pass), .timeout_o (tmo),
        .pass_count_o (pcnt), .fail_mask_o (mask),
        .cycle_count_o (cyc), .instr_count_o (ins)
    );

    riscv_selfcheck_monitor #(.TIMEOUT_CYCLES(50)) u_to (
        .clk (clk), .rst (rst),
        .retire_valid_i (retire), .trigger_i (trig_off),
        .mem (tif.master),
        .done_o (t_done), .pass_o (t_pass), .timeout_o (t_tmo),
        .pass_count_o (t_pcnt), .fail_mask_o (t_mask),
        .cycle_count_o (t_cyc), .instr_count_o (t_ins)
    );

    riscv_selfcheck_monitor #(.CNT_W(4)) u_sat (
        .clk (clk), .rst (rst),
        .retire_valid_i (retire), .trigger_i (trig_off),
        .mem (sif.master),
        .done_o (s_done), .pass_o (s_pass), .timeout_o (s_tmo),
        .pass_count_o (s_pcnt), .fail_mask_o (s_mask),
        .cycle_count_o (s_cyc), .instr_count_o (s_ins)
    );

    assign tif.mem_accept_i = 1'b0;
    assign tif.mem_ack_i    = 1'b0;
    assign tif.mem_error_i  = 1'b0;
    assign tif.mem_data_i   = '0;
    assign sif.mem_accept_i = 1'b0;
    assign sif.mem_ack_i    = 1'b0;
    assign sif.mem_error_i  = 1'b0;
    assign sif.mem_data_i   = '0;

    logic to_rd_seen = 1'b0;
    always @(posedge clk) if (tif.mem_rd_o) to_rd_seen <= 1'b1;

    logic [63:0] mem_w [6];
    int stall_cfg = 0;
    int ack_cfg = 0;
    int err_beat = -1;
    logic [31:0] alog [$];
    bit pend = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TCM responder with configurable accept stall and ack latency.
    initial begin
        int st;
        int ackc;
        int n;
        logic [31:0] a0;
        logic [63:0] pdata;
        logic perr;
        st = 0; ackc = 0; a0 = '0; pdata = '0; perr = 1'b0;
        mif.mem_accept_i = 1'b0;
        mif.mem_ack_i = 1'b0;
        mif.mem_error_i = 1'b0;
        mif.mem_data_i = '0;
        forever begin
            @(negedge clk);
            mif.mem_accept_i = 1'b0;
            mif.mem_ack_i = 1'b0;
            mif.mem_error_i = 1'b0;
            if (!rst) st = 0;
            if (pend) begin
                if (ackc == 0) begin
                    mif.mem_ack_i = 1'b1;
                    mif.mem_data_i = pdata;
                    mif.mem_error_i = perr;
                    pend = 0;
                end else begin
                    ackc--;
                end
            end else if (rst && (st != 0 || mif.mem_rd_o)) begin
                if (st != 0) begin
                    chk("rd_held", 64'(mif.mem_rd_o), 64'd1);
                    chk("addr_stable", 64'(mif.mem_addr_o), 64'(a0));
                end else begin
                    a0 = mif.mem_addr_o;
                end
                if (st < stall_cfg) begin
                    st++;
                end else begin
                    st = 0;
                    mif.mem_accept_i = 1'b1;
                    alog.push_back(mif.mem_addr_o);
                    n = int'((mif.mem_addr_o - 32'h80009000) >> 3);
                    pdata = (n >= 0 && n < 6) ? mem_w[n] : 64'd0;
                    perr = (n == err_beat);
                    if (ack_cfg == 0) begin
                        mif.mem_ack_i = 1'b1;
                        mif.mem_data_i = pdata;
                        mif.mem_error_i = perr;
                    end else begin
                        pend = 1;
                        ackc = ack_cfg - 1;
                    end
                end
            end
        end
    end

    task automatic set_word(input int k, input logic [31:0] v);
        mem_w[k/2][32*(k%2) +: 32] = v;
    endtask

    task automatic set_good();
        for (int k = 0; k < 10; k++) begin
            set_word(k, {16'h600D, 16'(k + 1)});
        end
        set_word(10, 32'd10);
        set_word(11, 32'd10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        retire = 2'b00;
        trig = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_and_run(input int n);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        retire = 2'b11;
        repeat (n) @(negedge clk);
        retire = 2'b00;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {done, pass, tmo, pcnt, mask, mif.mem_rd_o}, 64'd0);
        chk({tag, "_cnt"}, {cyc, ins}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) mem_w[i] = '0;
        set_good();

        // Test 1: clean run; timeout and saturation instances alongside.
        do_reset();
        check_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        retire = 2'b11;
        repeat (20) @(negedge clk);
        chk("sat_cyc", 64'(s_cyc), 64'd15);
        chk("sat_ins", 64'(s_ins), 64'd15);
        chk("to_not_yet", 64'(t_done), 64'd0);
        repeat (80) @(negedge clk);
        retire = 2'b00;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        wait_done();
        chk("t1_pass", 64'(pass), 64'd1);
        chk("t1_pcnt", 64'(pcnt), 64'd10);
        chk("t1_mask", 64'(mask), 64'd0);
        chk("t1_ins", 64'(ins), 64'd200);
        chk("t1_cyc", 64'(cyc), 64'd101);
        chk("t1_nreads", 64'(alog.size()), 64'd6);
        chk("t3_done", 64'(t_done), 64'd1);
        chk("t3_tmo", 64'(t_tmo), 64'd1);
        chk("t3_pass", 64'(t_pass), 64'd0);
        chk("t3_cyc", 64'(t_cyc), 64'd50);
        chk("t3_no_rd", 64'(to_rd_seen), 64'd0);
        chk("sat_cyc_end", 64'(s_cyc), 64'd15);

        // Test 2: one bad word and a wrong software pass count.
        do_reset();
        set_word(3, 32'hDEAD0004);
        set_word(10, 32'd9);
        ack_cfg = 1;
        release_and_run(100);
        wait_done();
        chk("t2_pass", 64'(pass), 64'd0);
        chk("t2_mask", 64'(mask), 64'h008);
        chk("t2_pcnt", 64'(pcnt), 64'd9);

        // Error beat: words 2 and 3 fail.
        do_reset();
        set_good();
        err_beat = 1;
        release_and_run(10);
        wait_done();
        chk("err_pass", 64'(pass), 64'd0);
        chk("err_mask", 64'(mask), 64'h00C);
        chk("err_pcnt", 64'(pcnt), 64'd8);
        err_beat = -1;

        // Test 4: stalled accept and delayed ack.
        do_reset();
        stall_cfg = 5;
        ack_cfg = 3;
        alog.delete();
        release_and_run(30);
        wait_done();
        chk("t4_pass", 64'(pass), 64'd1);
        chk("t4_pcnt", 64'(pcnt), 64'd10);
        chk("t4_nreads", 64'(alog.size()), 64'd6);
        for (int i = 0; i < 6 && i < alog.size(); i++) begin
            chk($sformatf("t4_addr%0d", i), 64'(alog[i]),
                64'(32'h80009000 + 32'(8 * i)));
        end

        // Test 5: reset mid-read with an ack still pending.
        do_reset();
        stall_cfg = 2;
        ack_cfg = 8;
        alog.delete();
        release_and_run(10);
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (alog.size() >= 3 && pend) break;
        end
        chk("t5_pending", 64'(pend), 64'd1);
        #2 rst = 1'b0;
        #1 check_zero("t5_async");
        @(negedge clk);
        @(negedge clk);
        alog.delete();
        release_and_run(100);
        wait_done();
        chk("t5_pass", 64'(pass), 64'd1);
        chk("t5_pcnt", 64'(pcnt), 64'd10);
        chk("t5_mask", 64'(mask), 64'd0);
        chk("t5_cyc", 64'(cyc), 64'd101);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
